mem_read_arbiter: RTL and testbench
===================================

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 1, giving the cycles from the mem_rstrb sampling edge to valid mem_rdata (legal 1..15).
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the width of all address ports.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports p0_addr / p1_addr  input  ADDR_W  requester byte address; only bits [ADDR_W-1:2] are meaningful.
REQ-006 The block SHALL have ports p0_rstrb / p1_rstrb  input  1  one-cycle read-request strobe.
REQ-007 The block SHALL have ports p0_rdata / p1_rdata  output  32  returned read word, registered.
REQ-008 The block SHALL have ports p0_rvalid / p1_rvalid  output  1  one-cycle pulse marking new rdata.
REQ-009 The block SHALL have ports p0_rbusy / p1_rbusy  output  1  request accepted, response not yet delivered.
REQ-010 The block SHALL have port mem_addr  output  ADDR_W  address to the shared memory, registered.
REQ-011 The block SHALL have port mem_rstrb  output  1  read strobe to the shared memory.
REQ-012 The block SHALL have port mem_rdata  input  32  data from the shared memory.
REQ-013 The block SHALL have port mem_owner  output  1  index of the port last granted, for debug.

Function
REQ-014 Each port SHALL accept a request when rstrb=1 and rbusy=0 at a clock edge: it latches the address, sets pending, and raises rbusy from the next cycle.
REQ-015 An rstrb seen while the port's rbusy=1 SHALL be ignored, with no change to the latched address or the state.
REQ-016 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT and RESP.
REQ-017 In IDLE with at least one port pending, the FSM SHALL grant one port, load mem_addr with that port's latched address, set mem_owner, and go to ISSUE.
REQ-018 If only one port is pending, that port SHALL be granted.
REQ-019 If both ports are pending, the port not equal to mem_owner SHALL be granted (round-robin).
REQ-020 In ISSUE, mem_rstrb SHALL be 1 for exactly that one cycle; the FSM then goes to WAIT with the counter loaded to MEM_LATENCY-1.
REQ-021 In WAIT, the counter SHALL decrement each edge; at the edge where the counter is 0, the FSM goes to RESP.
REQ-022 Entering RESP, the granted port's rdata SHALL be loaded from mem_rdata, and its rvalid=1 and rbusy=0 during the RESP cycle.
REQ-023 From RESP, the FSM SHALL return to IDLE unconditionally.
REQ-024 Latency SHALL be as follows: for a request accepted at edge E with no contention, mem_rstrb is high in the cycle after E+1 and rvalid is high in the cycle after E+MEM_LATENCY+2.
REQ-025 Each transaction SHALL occupy MEM_LATENCY+3 cycles, and the arbiter SHALL serve one transaction at a time.
REQ-026 mem_rstrb SHALL be 0 in every state except ISSUE.
REQ-027 mem_addr SHALL hold its last issued value outside ISSUE.
REQ-028 rdata SHALL hold its value until the next RESP for the same port; the other port's rdata SHALL be unaffected.
REQ-029 A port whose rvalid is high SHALL be able to issue a new rstrb in that same cycle, and it SHALL be accepted.
REQ-030 An rstrb from the non-granted port during ISSUE, WAIT or RESP SHALL be accepted if that port is not busy, and served in the next IDLE.
REQ-031 The memory SHALL never see two overlapping strobes, and no request SHALL be lost or duplicated.
REQ-032 A port pending while the other port is in service SHALL be granted at the next IDLE (starvation bound of one transaction).

Reset
REQ-033 While resetn=0, the FSM SHALL be IDLE and all pending flags, rbusy, rvalid and mem_rstrb SHALL be 0.
REQ-034 While resetn=0, mem_addr, p0_rdata and p1_rdata SHALL be 0, the counter SHALL be 0, and mem_owner SHALL be 1 so that port 0 wins the first tie.
REQ-035 Reset asserted mid-transaction SHALL discard the transaction: no rvalid is emitted afterwards, and any strobe in flight to memory is abandoned.
REQ-036 After resetn rises, the first accepted request SHALL be at the first edge with resetn=1.

Verification
REQ-037 The bench memory model SHALL return mem_rdata = {8'hA5, addr[25:2]} one cycle after mem_rstrb (MEM_LATENCY=1).
REQ-038 Bench scenario, single port 0 read: p0 strobe at edge E with addr 0x10 -> p0_rvalid high in the cycle after E+3, p0_rdata=0xA5000004, p0_rbusy high for 3 cycles.
REQ-039 Bench scenario, simultaneous strobes after reset: p0 0x20 and p1 0x40 -> p0 served first (0xA5000008), then p1 (0xA5000010), with p1 rvalid 4 cycles after p0 rvalid.
REQ-040 Bench scenario, round-robin under continuous load: both ports re-strobe on every rvalid for 8 transactions -> grants alternate 0,1,0,1,... and each port receives 4 responses.
REQ-041 Bench scenario, strobe while busy: p1 strobes 0x8 then 0xC one cycle later -> only 0x8 is issued, one p1 rvalid, p1_rdata=0xA5000002.
REQ-042 Bench scenario, reset in WAIT: resetn low for 1 cycle -> no rvalid afterwards, all outputs 0, and a new p1 request is served normally after release.
REQ-043 Bench scenario, MEM_LATENCY=3: a single request -> rvalid 5 cycles after the accept edge, with mem_rstrb high for exactly 1 cycle.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Two-port round-robin read arbiter in front of one fixed-latency memory.
// One transaction is in flight at a time; each takes MEM_LATENCY+3 cycles.
module mem_read_arbiter #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic              p0_rstrb,
   output logic [31:0]       p0_rdata,
   output logic              p0_rvalid,
   output logic              p0_rbusy,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic              p1_rstrb,
   output logic [31:0]       p1_rdata,
   output logic              p1_rvalid,
   output logic              p1_rbusy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rstrb,
   input  logic [31:0]       mem_rdata,
   output logic              mem_owner
);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_t;

   localparam logic [3:0] LatLoad = 4'(MEM_LATENCY - 1);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_owner;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rstrb;
   logic [1:0]        r_pend;
   logic [1:0]        r_busy;
   logic [1:0]        r_rvalid;
   logic [ADDR_W-1:0] r_addr  [2];
   logic [31:0]       r_rdata [2];

   logic [1:0]        w_rstrb;
   logic [ADDR_W-1:0] w_addr_in [2];
   logic [1:0]        w_accept;
   logic              w_grant;
   logic              w_grant_idx;
   logic              w_resp_enter;

   assign w_rstrb      = {p1_rstrb, p0_rstrb};
   assign w_addr_in[0] = p0_addr;
   assign w_addr_in[1] = p1_addr;

   // A strobe is only taken while the port has nothing outstanding.
   assign w_accept     = w_rstrb & ~r_busy;
   assign w_grant      = (r_state == StIdle) && (r_pend != 2'b00);
   // On a tie the port that was not served last wins.
   assign w_grant_idx  = (r_pend == 2'b11) ? ~r_owner : r_pend[1];
   assign w_resp_enter = (r_state == StWait) && (r_cnt == 4'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= StIdle;
         r_cnt       <= 4'd0;
         r_owner     <= 1'b1;
         r_mem_addr  <= '0;
         r_mem_rstrb <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_grant) begin
                  r_state     <= StIssue;
                  r_owner     <= w_grant_idx;
                  r_mem_addr  <= r_addr[w_grant_idx];
                  r_mem_rstrb <= 1'b1;
               end
            end
            StIssue: begin
               r_state     <= StWait;
               r_cnt       <= LatLoad;
               r_mem_rstrb <= 1'b0;
            end
            StWait: begin
               if (r_cnt == 4'd0) begin
                  r_state <= StResp;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            StResp: begin
               r_state <= StIdle;
            end
            default: begin
               r_state     <= StIdle;
               r_mem_rstrb <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pend   <= 2'b00;
         r_busy   <= 2'b00;
         r_rvalid <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_addr[i]  <= '0;
            r_rdata[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            r_rvalid[i] <= w_resp_enter && (r_owner == i[0]);
            if (w_resp_enter && (r_owner == i[0])) begin
               r_busy[i]  <= 1'b0;
               r_rdata[i] <= mem_rdata;
            end
            if (w_grant && (w_grant_idx == i[0])) begin
               r_pend[i] <= 1'b0;
            end
            // Accept cannot collide with grant or response: both need busy=1.
            if (w_accept[i]) begin
               r_pend[i] <= 1'b1;
               r_busy[i] <= 1'b1;
               r_addr[i] <= w_addr_in[i];
            end
         end
      end
   end

   assign p0_rdata  = r_rdata[0];
   assign p1_rdata  = r_rdata[1];
   assign p0_rvalid = r_rvalid[0];
   assign p1_rvalid = r_rvalid[1];
   assign p0_rbusy  = r_busy[0];
   assign p1_rbusy  = r_busy[1];
   assign mem_addr  = r_mem_addr;
   assign mem_rstrb = r_mem_rstrb;
   assign mem_owner = r_owner;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: two instances (latency 1 and 3) share one stimulus
// stream and are checked every cycle against a transaction-age model.
module tb_mem_read_arbiter;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] p0_addr, p1_addr;
   logic        p0_rstrb, p1_rstrb;

   logic [31:0] rd0 [N], rd1 [N], maddr [N], mrdata [N];
   logic        rv0 [N], rv1 [N], rb0 [N], rb1 [N], mrstrb [N], mown [N];

   always #5 clk = ~clk;

   mem_read_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) u_dut_l1 (
      .clk(clk), .resetn(resetn),
      .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_rdata(rd0[0]), .p0_rvalid(rv0[0]),
      .p0_rbusy(rb0[0]),
      .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_rdata(rd1[0]), .p1_rvalid(rv1[0]),
      .p1_rbusy(rb1[0]),
      .mem_addr(maddr[0]), .mem_rstrb(mrstrb[0]), .mem_rdata(mrdata[0]), .mem_owner(mown[0])
   );

   mem_read_arbiter #(.MEM_LATENCY(3), .ADDR_W(32)) u_dut_l3 (
      .clk(clk), .resetn(resetn),
      .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_rdata(rd0[1]), .p0_rvalid(rv0[1]),
      .p0_rbusy(rb0[1]),
      .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_rdata(rd1[1]), .p1_rvalid(rv1[1]),
      .p1_rbusy(rb1[1]),
      .mem_addr(maddr[1]), .mem_rstrb(mrstrb[1]), .mem_rdata(mrdata[1]), .mem_owner(mown[1])
   );

   function automatic int lat(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   function automatic void chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [dut%0d] at cycle %0d: got %h, want %h", nm, k, cyc, act, exp);
      end
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: data appears exactly lat(k) edges after the strobe edge, for one cycle.
   logic [31:0] mp_d [N][16];
   logic        mp_v [N][16];

   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         for (int s = 15; s > 0; s--) begin
            mp_d[k][s] <= mp_d[k][s-1];
            mp_v[k][s] <= mp_v[k][s-1];
         end
         mp_d[k][0] <= {8'hA5, maddr[k][25:2]};
         mp_v[k][0] <= mrstrb[k];
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++) begin
         mrdata[k] = (mp_v[k][lat(k)-1] === 1'b1) ? mp_d[k][lat(k)-1] : 32'hDEAD_BEEF;
      end
   end

   // Model: age counts cycles since the grant edge; 0 means free.
   int          m_age   [N];
   logic        m_owner [N];
   logic [31:0] m_maddr [N];
   logic        m_pend  [N][2];
   logic        m_busy  [N][2];
   logic        m_rv    [N][2];
   logic [31:0] m_addr  [N][2];
   logic [31:0] m_rdata [N][2];

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_age[k]   = 0;
         m_owner[k] = 1'b1;
         m_maddr[k] = 32'd0;
         for (int p = 0; p < 2; p++) begin
            m_pend[k][p]  = 1'b0;
            m_busy[k][p]  = 1'b0;
            m_rv[k][p]    = 1'b0;
            m_addr[k][p]  = 32'd0;
            m_rdata[k][p] = 32'd0;
         end
      end
   endtask

   task automatic model_step(int k, logic [1:0] stb, logic [31:0] a0, logic [31:0] a1);
      logic [1:0] acc;
      int         pick;
      int         l;
      l = lat(k);
      acc[0] = stb[0] && !m_busy[k][0];
      acc[1] = stb[1] && !m_busy[k][1];
      m_rv[k][0] = 1'b0;
      m_rv[k][1] = 1'b0;
      if (m_age[k] == 0) begin
         if (m_pend[k][0] || m_pend[k][1]) begin
            if (m_pend[k][0] && m_pend[k][1]) pick = m_owner[k] ? 0 : 1;
            else pick = m_pend[k][1] ? 1 : 0;
            m_owner[k]      = pick[0];
            m_maddr[k]      = m_addr[k][pick];
            m_pend[k][pick] = 1'b0;
            m_age[k]        = 1;
         end
      end else if (m_age[k] == l + 2) begin
         m_age[k] = 0;
      end else begin
         m_age[k]++;
         if (m_age[k] == l + 2) begin
            m_rdata[k][m_owner[k]] = {8'hA5, m_maddr[k][25:2]};
            m_busy[k][m_owner[k]]  = 1'b0;
            m_rv[k][m_owner[k]]    = 1'b1;
         end
      end
      if (acc[0]) begin
         m_pend[k][0] = 1'b1;
         m_busy[k][0] = 1'b1;
         m_addr[k][0] = a0;
      end
      if (acc[1]) begin
         m_pend[k][1] = 1'b1;
         m_busy[k][1] = 1'b1;
         m_addr[k][1] = a1;
      end
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) model_reset();
      else for (int k = 0; k < N; k++) model_step(k, {p1_rstrb, p0_rstrb}, p0_addr, p1_addr);
   end

   typedef struct {
      int          cyc;
      int          port;
      logic [31:0] val;
   } ev_t;

   ev_t rvq0[$], rvq1[$], stq0[$], stq1[$];

   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         chk("mem_rstrb", k, 32'(mrstrb[k]), 32'(m_age[k] == 1));
         chk("mem_addr",  k, maddr[k], m_maddr[k]);
         chk("mem_owner", k, 32'(mown[k]), 32'(m_owner[k]));
         chk("p0_rvalid", k, 32'(rv0[k]), 32'(m_rv[k][0]));
         chk("p1_rvalid", k, 32'(rv1[k]), 32'(m_rv[k][1]));
         chk("p0_rbusy",  k, 32'(rb0[k]), 32'(m_busy[k][0]));
         chk("p1_rbusy",  k, 32'(rb1[k]), 32'(m_busy[k][1]));
         chk("p0_rdata",  k, rd0[k], m_rdata[k][0]);
         chk("p1_rdata",  k, rd1[k], m_rdata[k][1]);
      end
      if (rv0[0])    rvq0.push_back('{cyc, 0, rd0[0]});
      if (rv1[0])    rvq0.push_back('{cyc, 1, rd1[0]});
      if (mrstrb[0]) stq0.push_back('{cyc, int'(mown[0]), maddr[0]});
      if (rv0[1])    rvq1.push_back('{cyc, 0, rd0[1]});
      if (rv1[1])    rvq1.push_back('{cyc, 1, rd1[1]});
      if (mrstrb[1]) stq1.push_back('{cyc, int'(mown[1]), maddr[1]});
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic clear_q();
      rvq0.delete();
      rvq1.delete();
      stq0.delete();
      stq1.delete();
   endtask

   initial begin
      int ce, busy_cnt, n0, n1, c0, c1;
      resetn   = 1'b0;
      p0_addr  = 32'd0;
      p1_addr  = 32'd0;
      p0_rstrb = 1'b0;
      p1_rstrb = 1'b0;
      tick(3);

      for (int k = 0; k < N; k++) begin
         chk("rst_owner",  k, 32'(mown[k]), 32'd1);
         chk("rst_maddr",  k, maddr[k], 32'd0);
         chk("rst_rstrb",  k, 32'(mrstrb[k]), 32'd0);
         chk("rst_rdata0", k, rd0[k], 32'd0);
         chk("rst_rbusy1", k, 32'(rb1[k]), 32'd0);
      end

      // Simultaneous strobes on the first edge after reset release.
      clear_q();
      resetn   = 1'b1;
      p0_addr  = 32'h20;
      p1_addr  = 32'h40;
      p0_rstrb = 1'b1;
      p1_rstrb = 1'b1;
      ce = cyc + 1;
      tick();
      p0_rstrb = 1'b0;
      p1_rstrb = 1'b0;
      tick(15);
      chk("tie_count", 0, rvq0.size(), 2);
      if (rvq0.size() == 2) begin
         chk("tie_first_port", 0, rvq0[0].port, 0);
         chk("tie_first_data", 0, rvq0[0].val, 32'hA500_0008);
         chk("tie_first_cyc",  0, rvq0[0].cyc, ce + 3);
         chk("tie_second_port", 0, rvq0[1].port, 1);
         chk("tie_second_data", 0, rvq0[1].val, 32'hA500_0010);
         chk("tie_gap", 0, rvq0[1].cyc - rvq0[0].cyc, 4);
      end

      // Single port-0 read; the latency-3 instance sees the same request.
      clear_q();
      p0_addr  = 32'h10;
      p0_rstrb = 1'b1;
      ce = cyc + 1;
      tick();
      p0_rstrb = 1'b0;
      busy_cnt = 0;
      repeat (10) begin
         if (rb0[0]) busy_cnt++;
         tick();
      end
      chk("single_busy_cycles", 0, busy_cnt, 3);
      chk("single_rv_count", 0, rvq0.size(), 1);
      chk("single_st_count", 0, stq0.size(), 1);
      if (rvq0.size() == 1 && stq0.size() == 1) begin
         chk("single_rv_cyc",  0, rvq0[0].cyc, ce + 3);
         chk("single_rv_data", 0, rvq0[0].val, 32'hA500_0004);
         chk("single_st_cyc",  0, stq0[0].cyc, ce + 1);
      end
      chk("lat3_rv_count", 1, rvq1.size(), 1);
      chk("lat3_st_count", 1, stq1.size(), 1);
      if (rvq1.size() == 1) chk("lat3_rv_cyc", 1, rvq1[0].cyc, ce + 5);

      // Strobe while busy is dropped.
      clear_q();
      p1_addr  = 32'h8;
      p1_rstrb = 1'b1;
      tick();
      p1_addr  = 32'hC;
      tick();
      p1_rstrb = 1'b0;
      tick(12);
      chk("busy_st_count", 0, stq0.size(), 1);
      chk("busy_rv_count", 0, rvq0.size(), 1);
      if (stq0.size() == 1) chk("busy_st_addr", 0, stq0[0].val, 32'h8);
      if (rvq0.size() == 1) begin
         chk("busy_rv_port", 0, rvq0[0].port, 1);
         chk("busy_rv_data", 0, rvq0[0].val, 32'hA500_0002);
      end

      // Continuous load: each port re-strobes on its own rvalid, 4 requests each.
      clear_q();
      p0_addr  = $urandom;
      p1_addr  = $urandom;
      p0_rstrb = 1'b1;
      p1_rstrb = 1'b1;
      tick();
      n0 = 1;
      n1 = 1;
      repeat (60) begin
         p0_rstrb = 1'b0;
         p1_rstrb = 1'b0;
         if (rv0[0] && n0 < 4) begin
            p0_addr  = $urandom;
            p0_rstrb = 1'b1;
            n0++;
         end
         if (rv1[0] && n1 < 4) begin
            p1_addr  = $urandom;
            p1_rstrb = 1'b1;
            n1++;
         end
         tick();
      end
      p0_rstrb = 1'b0;
      p1_rstrb = 1'b0;
      chk("rr_st_count", 0, stq0.size(), 8);
      foreach (stq0[i]) chk("rr_grant_order", 0, stq0[i].port, i % 2);
      c0 = 0;
      c1 = 0;
      foreach (rvq0[i]) begin
         if (rvq0[i].port == 0) c0++;
         else c1++;
      end
      chk("rr_p0_responses", 0, c0, 4);
      chk("rr_p1_responses", 0, c1, 4);
      tick(20);

      // Reset while the latency-1 instance is in its wait cycle.
      p0_addr  = $urandom;
      p0_rstrb = 1'b1;
      tick();
      p0_rstrb = 1'b0;
      tick(2);
      resetn = 1'b0;
      #1;
      chk("rstw_rstrb",  0, 32'(mrstrb[0]), 32'd0);
      chk("rstw_maddr",  0, maddr[0], 32'd0);
      chk("rstw_rbusy0", 0, 32'(rb0[0]), 32'd0);
      chk("rstw_rdata0", 0, rd0[0], 32'd0);
      chk("rstw_rdata1", 0, rd1[0], 32'd0);
      chk("rstw_owner",  0, 32'(mown[0]), 32'd1);
      tick();
      resetn = 1'b1;
      clear_q();
      tick(6);
      chk("rstw_no_rvalid", 0, rvq0.size() + rvq1.size(), 0);
      p1_addr  = 32'h44;
      p1_rstrb = 1'b1;
      ce = cyc + 1;
      tick();
      p1_rstrb = 1'b0;
      tick(10);
      chk("rstw_after_count", 0, rvq0.size(), 1);
      if (rvq0.size() == 1) begin
         chk("rstw_after_port", 0, rvq0[0].port, 1);
         chk("rstw_after_data", 0, rvq0[0].val, 32'hA500_0011);
         chk("rstw_after_cyc",  0, rvq0[0].cyc, ce + 3);
      end

      // Random traffic with occasional resets; the per-cycle compare does the checking.
      repeat (400) begin
         p0_rstrb = ($urandom_range(0, 3) == 0);
         p1_rstrb = ($urandom_range(0, 3) == 0);
         p0_addr  = $urandom;
         p1_addr  = $urandom;
         resetn   = ($urandom_range(0, 149) != 0);
         tick();
      end
      p0_rstrb = 1'b0;
      p1_rstrb = 1'b0;
      resetn   = 1'b1;
      tick(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
